// File: rtl/sha3_padder.sv
// SHA-3 message-block assembler: packs 32-bit words into a rate-sized block,
// applies 0x06...0x80 multi-rate padding and hands blocks to the permutation.
//
// state  | meaning
// ACCEPT | taking message words from the front end
// FILL   | last word seen; shifting zero words (0x80 in the final slot)
// FULL   | block complete, held on out until out_ack
module sha3_padder #(
  parameter int RATE_WORDS = 34
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [31:0]             in,
  input  logic                    in_valid,
  input  logic                    is_last,
  input  logic [1:0]              byte_num,
  output logic                    in_ready,
  output logic [32*RATE_WORDS-1:0] out,
  output logic                    out_valid,
  output logic                    out_last,
  input  logic                    out_ack
);

  localparam int CW = $clog2(RATE_WORDS + 1);

  typedef enum logic [1:0] {ACCEPT, FILL, FULL} state_t;

  state_t          state, state_nx;
  logic [CW-1:0]   cnt;
  logic            accept;
  logic            at_tail;
  logic            shift_en;
  logic [31:0]     pad_word;
  logic [31:0]     shift_word;

  assign accept  = in_valid & (state == ACCEPT);
  assign at_tail = (cnt == CW'(RATE_WORDS - 1));

  // Domain separator 0x06 lands in the first byte after the message data.
  always_comb begin
    pad_word = 32'h0600_0000;
    case (byte_num)
      2'd0: pad_word = 32'h0600_0000;
      2'd1: pad_word = {in[31:24], 24'h06_0000};
      2'd2: pad_word = {in[31:16], 16'h0600};
      2'd3: pad_word = {in[31:8], 8'h06};
      default: pad_word = 32'h0600_0000;
    endcase
  end

  always_comb begin
    shift_en   = 1'b0;
    shift_word = in;
    case (state)
      ACCEPT: begin
        if (accept) begin
          shift_en = 1'b1;
          if (is_last)
            shift_word = pad_word | (at_tail ? 32'h0000_0080 : 32'h0);
        end
      end
      FILL: begin
        shift_en   = 1'b1;
        shift_word = at_tail ? 32'h0000_0080 : 32'h0;
      end
      default: begin
        shift_en   = 1'b0;
        shift_word = in;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset)
      state <= ACCEPT;
    else
      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ACCEPT: begin
        if (accept && at_tail)
          state_nx = FULL;
        else if (accept && is_last)
          state_nx = FILL;
      end
      FILL: begin
        if (at_tail)
          state_nx = FULL;
      end
      FULL: begin
        if (out_ack)
          state_nx = ACCEPT;
      end
      default: state_nx = ACCEPT;
    endcase
  end

  always_comb begin
    in_ready  = (state == ACCEPT);
    out_valid = (state == FULL);
  end

  // out_last is loaded only on the shift that completes a block, so it moves with out_valid.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt      <= '0;
      out      <= '0;
      out_last <= 1'b0;
    end else if (shift_en) begin
      out <= {out[32*RATE_WORDS-33:0], shift_word};
      cnt <= cnt + CW'(1);
      if (at_tail)
        out_last <= (state == FILL) | is_last;
    end else if ((state == FULL) && out_ack) begin
      cnt      <= '0;
      out_last <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sha3_padder.sv
// Scoreboard bench for sha3_padder (RATE_WORDS=4): stimulus pushes expected
// blocks from a reference pad model, a negedge monitor pops and compares.
module tb_sha3_padder;

  localparam int R  = 4;
  localparam int BW = 32 * R;

  logic          clk = 1'b0;
  logic          reset;
  logic [31:0]   in;
  logic          in_valid;
  logic          is_last;
  logic [1:0]    byte_num;
  logic          in_ready;
  logic [BW-1:0] out;
  logic          out_valid;
  logic          out_last;
  logic          out_ack;

  typedef struct {
    logic [BW-1:0] blk;
    logic          last;
  } exp_t;

  exp_t        expq[$];
  logic [31:0] mw[$];
  int          checks   = 0;
  int          failures = 0;
  int          ack_mode = 0;

  sha3_padder #(.RATE_WORDS(R)) dut (
    .clk      (clk),
    .reset    (reset),
    .in       (in),
    .in_valid (in_valid),
    .is_last  (is_last),
    .byte_num (byte_num),
    .in_ready (in_ready),
    .out      (out),
    .out_valid(out_valid),
    .out_last (out_last),
    .out_ack  (out_ack)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [BW-1:0] act, input logic [BW-1:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  function automatic logic [31:0] pad(input logic [31:0] w, input logic [1:0] bn);
    case (bn)
      2'd0:    return 32'h0600_0000;
      2'd1:    return {w[31:24], 24'h06_0000};
      2'd2:    return {w[31:16], 16'h0600};
      default: return {w[31:8], 8'h06};
    endcase
  endfunction

  // Expected blocks for message mw followed by final partial word lw/bn.
  task automatic model_msg(input logic [31:0] lw, input logic [1:0] bn);
    logic [31:0] tmp[$];
    exp_t        e;
    int          nb;
    tmp = mw;
    tmp.push_back(pad(lw, bn));
    while (tmp.size() % R != 0) tmp.push_back(32'h0);
    tmp[tmp.size()-1] = tmp[tmp.size()-1] | 32'h0000_0080;
    nb = tmp.size() / R;
    for (int b = 0; b < nb; b++) begin
      e.blk = '0;
      for (int i = 0; i < R; i++) e.blk[BW-1-32*i -: 32] = tmp[b*R+i];
      e.last = (b == nb - 1);
      expq.push_back(e);
    end
  endtask

  task automatic model_full_block();
    exp_t e;
    e.blk = '0;
    for (int i = 0; i < R; i++) e.blk[BW-1-32*i -: 32] = mw[i];
    e.last = 1'b0;
    expq.push_back(e);
  endtask

  task automatic send(input logic [31:0] w, input logic last, input logic [1:0] bn, input int gap);
    int waited;
    waited   = 0;
    in_valid = 1'b0;
    repeat (gap) begin @(posedge clk); #1; end
    in       = w;
    is_last  = last;
    byte_num = bn;
    in_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      waited++;
      if (waited > 300) begin
        $display("FAIL send_timeout actual=no_in_ready required=in_ready_within_300");
        $display("TB_RESULT checks=%0d failures=%0d", checks + 1, failures + 1);
        $fatal(1);
      end
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    is_last  = 1'b0;
  endtask

  // out_valid must stay low for n more cycles after the accepting edge, then rise.
  task automatic check_rise(input int n);
    for (int i = 0; i < n; i++) begin
      chk("fill_no_valid", BW'(out_valid), BW'(0));
      @(posedge clk); #1;
    end
    chk("valid_rise", BW'(out_valid), BW'(1));
  endtask

  task automatic do_ack();
    ack_mode = 1;
    @(posedge clk); #1;
    chk("ack_in_ready", BW'(in_ready), BW'(1));
    chk("ack_valid_low", BW'(out_valid), BW'(0));
    ack_mode = 0;
  endtask

  task automatic reset_pulse();
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("rst_out", out, '0);
    chk("rst_valid", BW'(out_valid), BW'(0));
    chk("rst_last", BW'(out_last), BW'(0));
    chk("rst_in_ready", BW'(in_ready), BW'(1));
  endtask

  initial begin
    out_ack = 1'b0;
    forever begin
      @(negedge clk);
      out_ack = (ack_mode == 2) ? 1'($urandom_range(0, 1)) : (ack_mode == 1);
    end
  end

  initial begin
    logic prev_v;
    exp_t cur;
    prev_v   = 1'b0;
    cur.blk  = '0;
    cur.last = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev_v = 1'b0;
      end else begin
        if (out_valid && !prev_v) begin
          if (expq.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_block actual=%h required=no_block", out);
          end else begin
            cur = expq.pop_front();
            chk("block", out, cur.blk);
            chk("out_last", BW'(out_last), BW'(cur.last));
          end
        end else if (out_valid) begin
          chk("hold_block", out, cur.blk);
          chk("hold_last", BW'(out_last), BW'(cur.last));
        end else begin
          chk("last_without_valid", BW'(out_last), BW'(0));
        end
        prev_v = out_valid;
      end
    end
  end

  initial begin
    int          c;
    logic [31:0] lw;
    logic [1:0]  bn;
    reset    = 1'b1;
    in       = '0;
    in_valid = 1'b0;
    is_last  = 1'b0;
    byte_num = '0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    chk("reset_out", out, '0);
    chk("reset_valid", BW'(out_valid), BW'(0));
    chk("reset_in_ready", BW'(in_ready), BW'(1));

    // A,B,C then last word with 3 bytes in the final slot: no fill cycles.
    mw = '{32'hA0A1A2A3, 32'hB0B1B2B3, 32'hC0C1C2C3};
    model_msg(32'hAABBCCDD, 2'd3);
    foreach (mw[i]) send(mw[i], 1'b0, 2'd0, 0);
    send(32'hAABBCCDD, 1'b1, 2'd3, 0);
    check_rise(0);
    do_ack();

    // Empty message.
    mw.delete();
    model_msg(32'hFFFFFFFF, 2'd0);
    send(32'hFFFFFFFF, 1'b1, 2'd0, 0);
    check_rise(R - 1);
    do_ack();

    // Full block without is_last, held while ack is low; extra words dropped.
    mw = '{32'h01020304, 32'h05060708, 32'h090A0B0C, 32'h0D0E0F10};
    model_full_block();
    foreach (mw[i]) send(mw[i], 1'b0, 2'd0, 0);
    chk("full_valid", BW'(out_valid), BW'(1));
    in       = 32'hDEADBEEF;
    is_last  = 1'b1;
    byte_num = 2'd1;
    in_valid = 1'b1;
    repeat (10) begin
      @(posedge clk); #1;
      chk("full_in_ready", BW'(in_ready), BW'(0));
      chk("full_valid_hold", BW'(out_valid), BW'(1));
    end
    in_valid = 1'b0;
    is_last  = 1'b0;
    do_ack();

    // Reset mid-block, then reset during FULL, then a fresh message from slot 0.
    send(32'h11111111, 1'b0, 2'd0, 0);
    send(32'h22222222, 1'b0, 2'd0, 0);
    reset_pulse();
    mw = '{32'h31313131, 32'h32323232, 32'h33333333, 32'h34343434};
    model_full_block();
    foreach (mw[i]) send(mw[i], 1'b0, 2'd0, 0);
    @(posedge clk); #1;
    chk("pre_reset_valid", BW'(out_valid), BW'(1));
    reset_pulse();
    mw = '{32'h55667788};
    model_msg(32'h99AABBCC, 2'd1);
    send(32'h55667788, 1'b0, 2'd0, 0);
    send(32'h99AABBCC, 1'b1, 2'd1, 0);
    check_rise(R - 2);
    do_ack();

    // Random-length messages with random input gaps and ack delays.
    ack_mode = 2;
    for (int m = 0; m < 50; m++) begin
      mw.delete();
      c = $urandom_range(0, 9);
      for (int i = 0; i < c; i++) mw.push_back($urandom);
      lw = $urandom;
      bn = 2'($urandom_range(0, 3));
      model_msg(lw, bn);
      foreach (mw[i]) send(mw[i], 1'b0, 2'd0, $urandom_range(0, 3));
      send(lw, 1'b1, bn, $urandom_range(0, 3));
    end
    c = 0;
    while ((expq.size() != 0 || out_valid) && c < 2000) begin
      @(posedge clk); #1;
      c++;
    end
    chk("drain_queue", BW'(expq.size()), BW'(0));
    chk("drain_valid", BW'(out_valid), BW'(0));
    ack_mode = 0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sha3_padder.md
# sha3_padder

Message-block assembler for the SHA-3 core. Sits between the byte/word front end (UART word packer) and the Keccak-f permutation. It accumulates 32-bit message words into one rate-sized block and applies SHA-3 multi-rate padding (0x06 … 0x80) to the final partial word. It then presents each complete block to the permutation with a valid/ack handshake, flagging the message's last block.

## Interface
Parameters:
- RATE_WORDS, 34, block size in 32-bit words (34 = 1088-bit rate, SHA3-256); legal range 2..64

Ports:
- clk  in  1  clock; one clock domain, all logic on rising edge
- reset  in  1  synchronous, active-high reset
- in  in  32  message word, big-endian byte order (in[31:24] is first byte)
- in_valid  in  1  `in` carries a word this cycle
- is_last  in  1  qualifies `in`: this is the final (partial) word of the message
- byte_num  in  2  with is_last: number of valid leading bytes in `in` (0..3); ignored otherwise
- in_ready  out  1  block can accept a word this cycle
- out  out  32*RATE_WORDS  assembled block; first word in out[32*RATE_WORDS-1 -: 32]
- out_valid  out  1  `out` holds a complete block
- out_last  out  1  with out_valid: block is the message's final (padded) block
- out_ack  in  1  permutation has consumed `out`

## Operation
- State: ACCEPT, FILL, FULL; word counter cnt (0..RATE_WORDS).
- Buffer is a shift register: each shifted word w enters as out <= {out[32*RATE_WORDS-33:0], w}; cnt++.
- Padded word pad(in, byte_num): bn=0 → 0x06000000; 1 → {in[31:24],0x060000}; 2 → {in[31:16],0x0600}; 3 → {in[31:8],0x06}. Full-length final words are sent as a normal word followed by is_last with byte_num=0.
- ACCEPT: in_ready=1. Accept = in_valid & in_ready.
  - Non-last word: shift `in`. If cnt becomes RATE_WORDS → FULL, out_last<=0.
  - Last word: w = pad(in,byte_num); if cnt==RATE_WORDS-1, w |= 0x00000080, shift, → FULL, out_last<=1; else shift w → FILL.
- FILL: in_ready=0; one word per cycle: shift 0x00000000, or 0x00000080 when cnt==RATE_WORDS-1 (then → FULL, out_last<=1). A padded message never needs an extra block.
- FULL: in_ready=0, out_valid=1, out stable. On out_ack: cnt<=0, out_valid<=0, out_last<=0, → ACCEPT.
- out_ack outside FULL: ignored. in_valid outside ACCEPT: ignored (no accept, no state change).
- is_last, byte_num are sampled only on an accepted word.
- Reset (any state, mid-block included): state ACCEPT, cnt 0, out all-zero, out_valid 0, out_last 0, in_ready 1 from the first cycle after reset; partial block discarded.

## Timing
- in_ready and out_valid are decoded from registered state only; no combinational path from in_valid/out_ack.
- Accepted word appears in `out` the cycle after the accepting edge.
- Last word accepted at slot k (0-based): FILL lasts RATE_WORDS-1-k cycles; out_valid rises on the following cycle (immediately the next cycle if k = RATE_WORDS-1).
- FULL→ACCEPT: in_ready is high the cycle after the out_ack edge; throughput of back-to-back blocks is RATE_WORDS+1 cycles with ack held high.
- out_last changes only with out_valid.

## Test plan
- RATE_WORDS=34, single word 0x11223344 is_last bn=2 → after 33 fill cycles out_valid=1, out_last=1, top word 0x11220600, words 1..32 zero, bottom word 0x00000080.
- RATE_WORDS=4, words A,B,C then is_last bn=3 in=0xAABBCCDD → out={A,B,C,0xAABBCC86}, out_valid the next cycle, out_last=1, no FILL cycles.
- RATE_WORDS=4, 4 full words without is_last → out_valid=1, out_last=0; hold out_ack=0 for 10 cycles → out stable, in_ready=0, extra in_valid words dropped; ack → in_ready=1 next cycle.
- RATE_WORDS=4, empty message: is_last bn=0 at slot 0 → out={0x06000000,0,0,0x00000080}, out_last=1.
- RATE_WORDS=4, reset asserted after 2 words and again during FULL → next cycle out=0, out_valid=0, cnt=0; new message assembles from slot 0.
- Randomized in_valid gaps and out_ack delays over 50 messages of random length, checked against a reference pad model: every block bit-exact, exactly one out_last per message.
